// File: rtl/ad9361_mcs_sync_gen.sv
// AD9361 multi-chip-sync pulse generator.
// Software arms a sequence from a GPIO level. After an optional wait for the
// next GPS PPS edge and a programmable delay, it emits NUM_PULSES pulses on
// mcs_sync. The pulses are PULSE_CYCLES wide and GAP_CYCLES apart, so both
// RFICs, and several boards, latch MCS against a common time reference.
//
// Ports:
//   clk, rst     system clock; synchronous active-high reset
//   pps_in       GPS PPS, asynchronous to clk (synchronised internally)
//   arm          GPIO level; a rising edge seen in IDLE starts a sequence
//   abort        synchronous cancel, highest priority
//   align_pps    1 = wait for a PPS edge before the delay (sampled on arm)
//   delay        trigger-to-first-pulse delay in clk cycles (sampled on arm)
//   mcs_sync     registered MCS pulse output
//   pps_edge     one-cycle synchronised PPS rising edge (always running)
//   busy         high whenever the sequencer is not idle
//   done         one-cycle pulse after the last pulse of a sequence
//   timeout      sticky flag: PPS never arrived; cleared by the next accepted arm

module ad9361_mcs_sync_gen #(
  parameter int PULSE_CYCLES   = 8,
  parameter int GAP_CYCLES     = 64,
  parameter int NUM_PULSES     = 2,
  parameter int DELAY_W        = 16,
  parameter int TIMEOUT_CYCLES = 200000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pps_in,
  input  logic               arm,
  input  logic               abort,
  input  logic               align_pps,
  input  logic [DELAY_W-1:0] delay,
  output logic               mcs_sync,
  output logic               pps_edge,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  // Each counter is just wide enough for its terminal value. A counter is
  // reset on every state exit, so none of them can wrap.
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int NW = $clog2(NUM_PULSES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [NW-1:0] NUM_LAST   = NW'(NUM_PULSES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PPS,
    S_DELAY,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state;
  logic [2:0]         pps_sync;
  logic               arm_d;
  logic               arm_rise;
  logic [DELAY_W-1:0] dly_lat;
  logic [DELAY_W-1:0] dly_cnt;
  logic [TW-1:0]      tmo_cnt;
  logic [PW-1:0]      pul_cnt;
  logic [GW-1:0]      gap_cnt;
  logic [NW-1:0]      num_cnt;

  // PPS synchroniser. pps_sync[0] is the metastability catch flop. The edge
  // detect uses the two settled stages and is registered, so pps_edge is
  // glitch-free. A pulse that is sampled only once still gives exactly one
  // edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pps_sync <= '0;
      pps_edge <= 1'b0;
    end else begin
      pps_sync <= {pps_sync[1:0], pps_in};
      pps_edge <= pps_sync[1] & ~pps_sync[2];
    end
  end

  assign arm_rise = arm & ~arm_d;

  // Sequencer. All outputs are registered and change on the same edge as
  // the state transition they belong to, so mcs_sync edges line up exactly
  // with entry to and exit from PULSE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      arm_d    <= 1'b0;
      mcs_sync <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      dly_lat  <= '0;
      dly_cnt  <= '0;
      tmo_cnt  <= '0;
      pul_cnt  <= '0;
      gap_cnt  <= '0;
      num_cnt  <= '0;
    end else begin
      // Arm history always tracks the pin. An arm held high through an
      // abort or a whole sequence therefore never retriggers.
      arm_d <= arm;
      done  <= 1'b0;

      if (abort) begin
        // Abort beats everything, including an arm edge in the same cycle.
        // timeout is left alone so software can still read why a previous
        // attempt failed.
        state    <= S_IDLE;
        mcs_sync <= 1'b0;
        busy     <= 1'b0;
        dly_cnt  <= '0;
        tmo_cnt  <= '0;
        pul_cnt  <= '0;
        gap_cnt  <= '0;
        num_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm_rise) begin
              // align_pps only steers this one decision, so it is used
              // here directly. delay is needed later, so it is latched.
              dly_lat <= delay;
              timeout <= 1'b0;
              busy    <= 1'b1;
              dly_cnt <= '0;
              tmo_cnt <= '0;
              pul_cnt <= '0;
              gap_cnt <= '0;
              num_cnt <= '0;
              state   <= align_pps ? S_WAIT_PPS : S_DELAY;
            end
          end

          S_WAIT_PPS: begin
            // If the PPS edge and the timeout land on the same cycle, the
            // PPS edge is honoured.
            if (pps_edge) begin
              tmo_cnt <= '0;
              state   <= S_DELAY;
            end else if (tmo_cnt == TMO_LAST) begin
              tmo_cnt <= '0;
              timeout <= 1'b1;
              busy    <= 1'b0;
              state   <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end

          S_DELAY: begin
            // DELAY lasts dly_lat+1 cycles. delay = 0 therefore still
            // spends the one cycle that moves the trigger into PULSE.
            if (dly_cnt == dly_lat) begin
              dly_cnt  <= '0;
              mcs_sync <= 1'b1;
              state    <= S_PULSE;
            end else begin
              dly_cnt <= dly_cnt + 1'b1;
            end
          end

          S_PULSE: begin
            if (pul_cnt == PULSE_LAST) begin
              pul_cnt  <= '0;
              mcs_sync <= 1'b0;
              if (num_cnt == NUM_LAST) begin
                num_cnt <= '0;
                done    <= 1'b1;
                state   <= S_DONE;
              end else begin
                num_cnt <= num_cnt + 1'b1;
                state   <= S_GAP;
              end
            end else begin
              pul_cnt <= pul_cnt + 1'b1;
            end
          end

          S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt  <= '0;
              mcs_sync <= 1'b1;
              state    <= S_PULSE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end

          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end

          default: begin
            mcs_sync <= 1'b0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
